// File: rtl/handshake_monitor_pkg.sv
// Shared types for the ready/valid handshake monitor: per-channel FSM states
// and the 2-bit error codes reported through the first-error capture.
package handshake_monitor_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } chan_state_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_DROP    = 2'd1,
        ERR_DATA    = 2'd2,
        ERR_TIMEOUT = 2'd3
    } err_code_t;

endpackage

// File: rtl/handshake_chan_checker.sv
// One monitored ready/valid channel: stall FSM, payload capture, stall timer,
// saturating statistics counters and sticky protocol-error flags.
module handshake_chan_checker
    import handshake_monitor_pkg::*;
#(
    parameter int DATA_W  = 4,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_valid,
    input  logic              i_ready,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_clear,
    output logic [CNT_W-1:0]  o_xfer_count,
    output logic [CNT_W-1:0]  o_stall_count,
    output logic              o_err_drop,
    output logic              o_err_data,
    output logic              o_err_timeout,
    output logic              o_ev_drop,
    output logic              o_ev_data,
    output logic              o_ev_timeout
);

    localparam int TMR_W = $clog2(TIMEOUT + 1);

    chan_state_t       r_state;
    logic [TMR_W-1:0]  r_timer;
    logic [DATA_W-1:0] r_cap;
    logic [CNT_W-1:0]  r_xfer_count;
    logic [CNT_W-1:0]  r_stall_count;
    logic              r_err_drop;
    logic              r_err_data;
    logic              r_err_timeout;

    logic w_xfer;
    logic w_stall;
    logic w_pend;
    logic w_ev_drop;
    logic w_ev_data;
    logic w_ev_timeout;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign w_xfer  = i_valid & i_ready;
    assign w_stall = i_valid & ~i_ready;
    assign w_pend  = (r_state == PENDING);

    // Event pulses are suppressed under clear so that clear always wins.
    assign w_ev_drop    = w_pend & ~i_valid & ~i_clear;
    assign w_ev_data    = w_pend & i_valid & (i_data != r_cap) & ~i_clear;
    assign w_ev_timeout = w_pend & w_stall & (r_timer == TMR_W'(TIMEOUT - 1)) & ~i_clear;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= IDLE;
            r_timer       <= '0;
            r_xfer_count  <= '0;
            r_stall_count <= '0;
            r_err_drop    <= 1'b0;
            r_err_data    <= 1'b0;
            r_err_timeout <= 1'b0;
        end else if (i_clear) begin
            r_state       <= IDLE;
            r_timer       <= '0;
            r_xfer_count  <= '0;
            r_stall_count <= '0;
            r_err_drop    <= 1'b0;
            r_err_data    <= 1'b0;
            r_err_timeout <= 1'b0;
        end else begin
            if (w_xfer)  r_xfer_count  <= sat_inc(r_xfer_count);
            if (w_stall) r_stall_count <= sat_inc(r_stall_count);
            r_err_drop    <= r_err_drop    | w_ev_drop;
            r_err_data    <= r_err_data    | w_ev_data;
            r_err_timeout <= r_err_timeout | w_ev_timeout;
            case (r_state)
                IDLE: begin
                    if (w_stall) begin
                        r_state <= PENDING;
                        r_timer <= TMR_W'(1);
                    end
                end
                PENDING: begin
                    if (!i_valid || i_ready) begin
                        r_state <= IDLE;
                        r_timer <= '0;
                    end else if (r_timer != TMR_W'(TIMEOUT)) begin
                        r_timer <= r_timer + TMR_W'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_timer <= '0;
                end
            endcase
        end
    end

    // Payload is only meaningful while PENDING, so it needs no reset.
    always_ff @(posedge i_clk) begin
        if (r_state == IDLE && w_stall) begin
            r_cap <= i_data;
        end
    end

    assign o_xfer_count  = r_xfer_count;
    assign o_stall_count = r_stall_count;
    assign o_err_drop    = r_err_drop;
    assign o_err_data    = r_err_data;
    assign o_err_timeout = r_err_timeout;
    assign o_ev_drop     = w_ev_drop;
    assign o_ev_data     = w_ev_data;
    assign o_ev_timeout  = w_ev_timeout;

endmodule

// File: rtl/handshake_monitor.sv
// Multi-channel ready/valid protocol monitor: one checker per channel plus
// first-error capture (lowest channel wins, timeout > data > drop) and err_any.
module handshake_monitor
    import handshake_monitor_pkg::*;
#(
    parameter int NUM_CH  = 3,
    parameter int DATA_W  = 4,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input  logic                                       CLK,
    input  logic                                       ASYNCRESETN,
    input  logic [NUM_CH-1:0]                          valid,
    input  logic [NUM_CH-1:0]                          ready,
    input  logic [NUM_CH*DATA_W-1:0]                   data,
    input  logic                                       clear,
    output logic [NUM_CH*CNT_W-1:0]                    xfer_count,
    output logic [NUM_CH*CNT_W-1:0]                    stall_count,
    output logic [NUM_CH-1:0]                          err_drop,
    output logic [NUM_CH-1:0]                          err_data,
    output logic [NUM_CH-1:0]                          err_timeout,
    output logic                                       err_any,
    output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] first_err_ch,
    output logic [1:0]                                 first_err_code
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [NUM_CH-1:0] w_ev_drop;
    logic [NUM_CH-1:0] w_ev_data;
    logic [NUM_CH-1:0] w_ev_timeout;

    logic              w_hit;
    logic [CH_W-1:0]   w_hit_ch;
    err_code_t         w_hit_code;

    logic [CH_W-1:0]   r_first_ch;
    err_code_t         r_first_code;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
        handshake_chan_checker #(
            .DATA_W  (DATA_W),
            .TIMEOUT (TIMEOUT),
            .CNT_W   (CNT_W)
        ) u_chk (
            .i_clk         (CLK),
            .i_rst_n       (ASYNCRESETN),
            .i_valid       (valid[g]),
            .i_ready       (ready[g]),
            .i_data        (data[g*DATA_W +: DATA_W]),
            .i_clear       (clear),
            .o_xfer_count  (xfer_count[g*CNT_W +: CNT_W]),
            .o_stall_count (stall_count[g*CNT_W +: CNT_W]),
            .o_err_drop    (err_drop[g]),
            .o_err_data    (err_data[g]),
            .o_err_timeout (err_timeout[g]),
            .o_ev_drop     (w_ev_drop[g]),
            .o_ev_data     (w_ev_data[g]),
            .o_ev_timeout  (w_ev_timeout[g])
        );
    end

    // Scan from the top down so the lowest-indexed erroring channel is left standing.
    always_comb begin
        w_hit      = 1'b0;
        w_hit_ch   = '0;
        w_hit_code = ERR_NONE;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (w_ev_drop[i] | w_ev_data[i] | w_ev_timeout[i]) begin
                w_hit    = 1'b1;
                w_hit_ch = CH_W'(i);
                if (w_ev_timeout[i]) begin
                    w_hit_code = ERR_TIMEOUT;
                end else if (w_ev_data[i]) begin
                    w_hit_code = ERR_DATA;
                end else begin
                    w_hit_code = ERR_DROP;
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            r_first_ch   <= '0;
            r_first_code <= ERR_NONE;
        end else if (clear) begin
            r_first_ch   <= '0;
            r_first_code <= ERR_NONE;
        end else if (r_first_code == ERR_NONE && w_hit) begin
            r_first_ch   <= w_hit_ch;
            r_first_code <= w_hit_code;
        end
    end

    assign first_err_ch   = r_first_ch;
    assign first_err_code = r_first_code;
    assign err_any        = |{err_drop, err_data, err_timeout};

endmodule

// File: tb/tb_handshake_monitor.sv
// Directed bench for handshake_monitor (NUM_CH=3, TIMEOUT=4); a second
// instance with 2-bit counters shares the stimulus to exercise saturation.
module tb_handshake_monitor;

    localparam int NCH = 3;
    localparam int DW  = 4;
    localparam int CW  = 16;
    localparam int SW  = 2;

    logic                CLK = 1'b0;
    logic                ASYNCRESETN;
    logic [NCH-1:0]      valid;
    logic [NCH-1:0]      ready;
    logic [NCH*DW-1:0]   data;
    logic                clear;

    logic [NCH*CW-1:0]   xfer_count, stall_count;
    logic [NCH-1:0]      err_drop, err_data, err_timeout;
    logic                err_any;
    logic [1:0]          first_err_ch, first_err_code;

    logic [NCH*SW-1:0]   s_xfer_count, s_stall_count;
    logic [NCH-1:0]      s_err_drop, s_err_data, s_err_timeout;
    logic                s_err_any;
    logic [1:0]          s_first_err_ch, s_first_err_code;

    int n_pass  = 0;
    int n_total = 0;

    always #5 CLK = ~CLK;

    handshake_monitor #(.NUM_CH(NCH), .DATA_W(DW), .TIMEOUT(4), .CNT_W(CW)) dut (
        .CLK(CLK), .ASYNCRESETN(ASYNCRESETN), .valid(valid), .ready(ready),
        .data(data), .clear(clear), .xfer_count(xfer_count), .stall_count(stall_count),
        .err_drop(err_drop), .err_data(err_data), .err_timeout(err_timeout),
        .err_any(err_any), .first_err_ch(first_err_ch), .first_err_code(first_err_code)
    );

    handshake_monitor #(.NUM_CH(NCH), .DATA_W(DW), .TIMEOUT(4), .CNT_W(SW)) dut_s (
        .CLK(CLK), .ASYNCRESETN(ASYNCRESETN), .valid(valid), .ready(ready),
        .data(data), .clear(clear), .xfer_count(s_xfer_count), .stall_count(s_stall_count),
        .err_drop(s_err_drop), .err_data(s_err_data), .err_timeout(s_err_timeout),
        .err_any(s_err_any), .first_err_ch(s_first_err_ch), .first_err_code(s_first_err_code)
    );

    typedef struct {
        logic [2:0]  v;
        logic [2:0]  r;
        logic [11:0] d;
        logic        clr;
        int          x0;
        int          x1;
        int          s0;
        int          s1;
        logic        ea;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic drive(input logic [2:0] v, input logic [2:0] r, input logic [11:0] d, input logic clr);
        valid = v;
        ready = r;
        data  = d;
        clear = clr;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [CW-1:0] xc(input int ch);
        return xfer_count[ch*CW +: CW];
    endfunction

    function automatic logic [CW-1:0] sc(input int ch);
        return stall_count[ch*CW +: CW];
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        ASYNCRESETN = 1'b0;
        drive(3'b000, 3'b000, 12'h000, 1'b0);
        #1;
        chk("rst_xfer", xfer_count, '0);
        chk("rst_stall", stall_count, '0);
        chk("rst_err_any", err_any, 1'b0);
        chk("rst_first_code", first_err_code, 2'd0);
        chk("rst_first_ch", first_err_ch, 2'd0);
        tick();
        tick();
        ASYNCRESETN = 1'b1;

        // Back-to-back transfers on ch0, then a 3-cycle stall on ch1 resolved by ready.
        for (int k = 1; k <= 5; k++)
            tbl.push_back('{3'b001, 3'b001, 12'h000, 1'b0, k, 0, 0, 0, 1'b0});
        tbl.push_back('{3'b010, 3'b000, 12'h0A0, 1'b0, 5, 0, 0, 1, 1'b0});
        tbl.push_back('{3'b010, 3'b000, 12'h0A0, 1'b0, 5, 0, 0, 2, 1'b0});
        tbl.push_back('{3'b010, 3'b000, 12'h0A0, 1'b0, 5, 0, 0, 3, 1'b0});
        tbl.push_back('{3'b010, 3'b010, 12'h0A0, 1'b0, 5, 1, 0, 3, 1'b0});
        tbl.push_back('{3'b000, 3'b000, 12'h000, 1'b0, 5, 1, 0, 3, 1'b0});

        foreach (tbl[i]) begin
            drive(tbl[i].v, tbl[i].r, tbl[i].d, tbl[i].clr);
            tick();
            chk($sformatf("vec%0d_xfer0", i), xc(0), CW'(tbl[i].x0));
            chk($sformatf("vec%0d_xfer1", i), xc(1), CW'(tbl[i].x1));
            chk($sformatf("vec%0d_stall0", i), sc(0), CW'(tbl[i].s0));
            chk($sformatf("vec%0d_stall1", i), sc(1), CW'(tbl[i].s1));
            chk($sformatf("vec%0d_err_any", i), err_any, tbl[i].ea);
        end

        // ch2 payload changes mid-stall.
        drive(3'b100, 3'b000, 12'h300, 1'b0);
        tick();
        chk("data_pre_err", err_data[2], 1'b0);
        drive(3'b100, 3'b000, 12'h500, 1'b0);
        tick();
        chk("data_err2", err_data[2], 1'b1);
        chk("data_first_ch", first_err_ch, 2'd2);
        chk("data_first_code", first_err_code, 2'd2);
        chk("data_err_any", err_any, 1'b1);
        // Clear coincides with ch2 dropping valid: clear must win.
        drive(3'b000, 3'b000, 12'h000, 1'b1);
        tick();
        chk("clr_err_any", err_any, 1'b0);
        chk("clr_drop2", err_drop[2], 1'b0);
        chk("clr_first_code", first_err_code, 2'd0);
        chk("clr_xfer0", xc(0), '0);
        chk("clr_stall1", sc(1), '0);
        drive(3'b000, 3'b000, 12'h000, 1'b0);
        tick();
        chk("clr_fsm_idle", err_drop[2], 1'b0);

        // ch0 stalls 6 cycles against TIMEOUT=4.
        for (int k = 1; k <= 6; k++) begin
            drive(3'b001, 3'b000, 12'h000, 1'b0);
            tick();
            chk($sformatf("tmo_cyc%0d", k), err_timeout[0], (k >= 4) ? 1'b1 : 1'b0);
        end
        chk("tmo_stall0", sc(0), CW'(6));
        chk("tmo_first_code", first_err_code, 2'd3);
        chk("tmo_first_ch", first_err_ch, 2'd0);
        drive(3'b001, 3'b001, 12'h000, 1'b0);
        tick();
        drive(3'b000, 3'b000, 12'h000, 1'b1);
        tick();
        drive(3'b000, 3'b000, 12'h000, 1'b0);

        // ch0 drop and ch1 timeout on the same edge, later ch2 drop.
        drive(3'b010, 3'b000, 12'h000, 1'b0);
        tick();
        tick();
        drive(3'b011, 3'b000, 12'h000, 1'b0);
        tick();
        chk("tie_pre_any", err_any, 1'b0);
        drive(3'b010, 3'b000, 12'h000, 1'b0);
        tick();
        chk("tie_first_ch", first_err_ch, 2'd0);
        chk("tie_first_code", first_err_code, 2'd1);
        chk("tie_drop0", err_drop[0], 1'b1);
        chk("tie_tmo1", err_timeout[1], 1'b1);
        drive(3'b100, 3'b000, 12'h000, 1'b0);
        tick();
        drive(3'b000, 3'b000, 12'h000, 1'b0);
        tick();
        chk("later_drop2", err_drop[2], 1'b1);
        chk("later_first_ch", first_err_ch, 2'd0);
        chk("later_first_code", first_err_code, 2'd1);

        // Saturation on the 2-bit-counter instance, then clear during transfers.
        drive(3'b000, 3'b000, 12'h000, 1'b1);
        tick();
        for (int k = 0; k < 4; k++) begin
            drive(3'b001, 3'b001, 12'h000, 1'b0);
            tick();
        end
        chk("sat_xfer0_s", s_xfer_count[0*SW +: SW], 2'd3);
        chk("sat_xfer0_w", xc(0), CW'(4));
        for (int k = 0; k < 4; k++) begin
            drive(3'b010, 3'b000, 12'h000, 1'b0);
            tick();
        end
        chk("sat_stall1_s", s_stall_count[1*SW +: SW], 2'd3);
        chk("sat_err_any_s", s_err_any, 1'b1);
        drive(3'b011, 3'b011, 12'h000, 1'b1);
        tick();
        chk("clrx_xfer_s", s_xfer_count, '0);
        chk("clrx_stall_s", s_stall_count, '0);
        chk("clrx_err_any_s", s_err_any, 1'b0);
        chk("clrx_xfer_w", xfer_count, '0);
        drive(3'b000, 3'b000, 12'h000, 1'b0);
        tick();
        chk("clrx_idle_err", s_err_any, 1'b0);

        // Asynchronous reset in the middle of a stall episode.
        for (int k = 0; k < 3; k++) begin
            drive(3'b001, 3'b000, 12'h000, 1'b0);
            tick();
        end
        chk("prerst_stall0", sc(0), CW'(3));
        #2;
        ASYNCRESETN = 1'b0;
        #1;
        chk("arst_stall0", sc(0), '0);
        chk("arst_stall0_s", s_stall_count, '0);
        drive(3'b000, 3'b000, 12'h000, 1'b0);
        tick();
        ASYNCRESETN = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive(3'b001, 3'b000, 12'h000, 1'b0);
            tick();
        end
        chk("postrst_err_any", err_any, 1'b0);
        chk("postrst_stall0", sc(0), CW'(3));
        drive(3'b001, 3'b001, 12'h000, 1'b0);
        tick();
        drive(3'b000, 3'b000, 12'h000, 1'b0);
        tick();
        chk("postrst_final_any", err_any, 1'b0);
        chk("postrst_xfer0", xc(0), CW'(1));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
